// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 classic arbiter, round-robin, grant locked for the owner's whole cyc.
// Define WB_ARB_TIMEOUT_EN to compile in the watchdog that aborts transfers hung for TIMEOUT_CYCLES.

module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  gnt_o
);

    // state   | meaning
    // IDLE    | no owner, all slave outputs low
    // GNT0    | m0 owns the bus until it drops cyc
    // GNT1    | m1 owns the bus until it drops cyc
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 2..65535");
    end

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        last_q;
    logic        last_d;

    logic        gnt0;
    logic        gnt1;
    logic        granted;

    logic [31:0] own_adr;
    logic [31:0] own_dat;
    logic [3:0]  own_sel;
    logic        own_we;
    logic        own_cyc;
    logic        own_stb;

    logic        abort_q;
    logic        wd_fire;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    state_d = ST_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last resets to 1 so that m0 wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign gnt0    = (state_q == ST_GNT0);
    assign gnt1    = (state_q == ST_GNT1);
    assign granted = gnt0 | gnt1;
    assign gnt_o   = {gnt1, gnt0};

    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (gnt0) begin
            own_adr = m0_adr_i;
            own_dat = m0_dat_i;
            own_sel = m0_sel_i;
            own_we  = m0_we_i;
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
        end else if (gnt1) begin
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
            own_sel = m1_sel_i;
            own_we  = m1_we_i;
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q;

    // Fires in the stb cycle that brings the count to TIMEOUT_CYCLES.
    assign wd_fire = granted & own_cyc & own_stb & ~abort_q & ~s_ack_i & ~s_err_i
                     & (wd_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            if (!granted || !own_cyc || s_ack_i || s_err_i || abort_q || wd_fire) begin
                wd_cnt_q <= '0;
            end else if (own_stb) begin
                wd_cnt_q <= wd_cnt_q + 16'd1;
            end

            if (!granted || !own_cyc) begin
                abort_q <= 1'b0;
            end else if (wd_fire) begin
                abort_q <= 1'b1;
            end
        end
    end
`else
    assign abort_q = 1'b0;
    assign wd_fire = 1'b0;
`endif

    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign s_we_o  = own_we;
    assign s_cyc_o = own_cyc & ~abort_q;
    assign s_stb_o = own_stb & ~abort_q;

    // Responses arriving after an abort belong to a dead transfer and are dropped.
    assign m0_dat_o = (gnt0 && !abort_q) ? s_dat_i : 32'h0;
    assign m1_dat_o = (gnt1 && !abort_q) ? s_dat_i : 32'h0;
    assign m0_ack_o = gnt0 & ~abort_q & s_ack_i;
    assign m1_ack_o = gnt1 & ~abort_q & s_ack_i;
    assign m0_err_o = gnt0 & (wd_fire | (~abort_q & s_err_i));
    assign m1_err_o = gnt1 & (wd_fire | (~abort_q & s_err_i));

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: reset, grant latency, round robin, locking, watchdog, async reset.

module tb_wb_arbiter_2m;

    logic        clk;
    logic        reset_n;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]  gnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_sel_i (m0_sel_i),
        .m0_we_i  (m0_we_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_sel_i (m1_sel_i),
        .m1_we_i  (m1_we_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .gnt_o    (gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change here, checks follow a further #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_set(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we;
        m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    endtask

    task automatic m1_set(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we;
        m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    endtask

    initial begin
        reset_n = 1'b0;
        m0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // reset state
        step();
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_stb_o), 32'h0);
        check("rst_s_adr", s_adr_o, 32'h0);
        check("rst_m_resp", {28'h0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'h0);
        reset_n = 1'b1;

        // only m1 requests: grant appears one cycle later
        step(); step();
        m1_set(1'b1, 1'b0, 32'h0000_4444, 32'h0, 4'hF);
        #1;
        check("lat_gnt_n", 32'(gnt_o), 32'h0);
        check("lat_scyc_n", 32'(s_cyc_o), 32'h0);
        step(); #1;
        check("lat_gnt_n1", 32'(gnt_o), 32'h2);
        check("lat_scyc_n1", 32'(s_cyc_o), 32'h1);
        check("lat_sadr_n1", s_adr_o, 32'h0000_4444);
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        #1;
        check("m1_rd_dat", m1_dat_o, 32'h1234_5678);
        check("m1_rd_ack", 32'(m1_ack_o), 32'h1);
        check("m0_dat_zero", m0_dat_o, 32'h0);
        step();
        s_ack_i = 1'b0;
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); #1;
        check("idle_gnt", 32'(gnt_o), 32'h0);
        check("idle_sadr", s_adr_o, 32'h0);

        // tie after m1 was last: m0 wins, read 0x1000
        step();
        m0_set(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        m1_set(1'b1, 1'b1, 32'h0000_2000, 32'h5555_AAAA, 4'hF);
        step(); #1;
        check("tie_gnt", 32'(gnt_o), 32'h1);
        check("tie_sadr", s_adr_o, 32'h0000_1000);
        check("tie_swe", 32'(s_we_o), 32'h0);
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        check("m0_rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("m0_rd_ack", 32'(m0_ack_o), 32'h1);
        check("m1_no_ack", 32'(m1_ack_o), 32'h0);
        check("m1_no_dat", m1_dat_o, 32'h0);
        step();
        s_ack_i = 1'b0;
        m0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("drop_gnt_hold", 32'(gnt_o), 32'h1);
        check("drop_scyc", 32'(s_cyc_o), 32'h0);
        step(); #1;
        check("handover_gnt", 32'(gnt_o), 32'h2);
        check("handover_scyc", 32'(s_cyc_o), 32'h1);
        check("handover_sdat", s_dat_o, 32'h5555_AAAA);
        s_ack_i = 1'b1;
        step();
        s_ack_i = 1'b0;
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); step();

        // 20 back-to-back single beats from both masters must alternate, starting with m0
        m0_set(1'b1, 1'b0, 32'h0000_A000, 32'h0, 4'hF);
        m1_set(1'b1, 1'b0, 32'h0000_B000, 32'h0, 4'hF);
        step();
        for (int i = 0; i < 20; i++) begin
            #1;
            check("rr_gnt", 32'(gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_sadr", s_adr_o, (i % 2 == 0) ? 32'h0000_A000 : 32'h0000_B000);
            s_ack_i = 1'b1;
            #1;
            check("rr_ack", {30'h0, m1_ack_o, m0_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            s_ack_i = 1'b0;
            if (i % 2 == 0) m0_set(1'b0, 1'b0, 32'h0000_A000, 32'h0, 4'hF);
            else            m1_set(1'b0, 1'b0, 32'h0000_B000, 32'h0, 4'hF);
            step();
            if (i % 2 == 0) m0_set(1'b1, 1'b0, 32'h0000_A000, 32'h0, 4'hF);
            else            m1_set(1'b1, 1'b0, 32'h0000_B000, 32'h0, 4'hF);
        end
        m0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); step(); step();

        // m0 locks the bus for 4 writes while m1 waits
        m0_set(1'b1, 1'b1, 32'h0000_0100, 32'h0000_00A0, 4'b0011);
        step();
        m1_set(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            m0_set(1'b1, 1'b1, 32'h0000_0100 + 32'(4 * k), 32'h0000_00A0 + 32'(k), 4'b0011);
            s_ack_i = 1'b1;
            #1;
            check("lock_gnt", 32'(gnt_o), 32'h1);
            check("lock_sadr", s_adr_o, 32'h0000_0100 + 32'(4 * k));
            check("lock_sdat", s_dat_o, 32'h0000_00A0 + 32'(k));
            check("lock_ssel_we", {27'h0, s_we_o, s_sel_o}, 32'h13);
            check("lock_m1_ack", 32'(m1_ack_o), 32'h0);
            step();
        end
        s_ack_i = 1'b0;
        m0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("lock_release_hold", 32'(gnt_o), 32'h1);
        step(); #1;
        check("lock_release_gnt", 32'(gnt_o), 32'h2);
        check("lock_release_sadr", s_adr_o, 32'h0000_0200);
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); step();

`ifdef WB_ARB_TIMEOUT_EN
        // hung slave: err pulse in the 8th stb cycle, then bus aborted
        m0_set(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        step();
        for (int c = 1; c <= 7; c++) begin
            #1;
            check("wd_pre_err", 32'(m0_err_o), 32'h0);
            check("wd_pre_stb", 32'(s_stb_o), 32'h1);
            step();
        end
        m1_set(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        #1;
        check("wd_err_pulse", 32'(m0_err_o), 32'h1);
        check("wd_err_m1", 32'(m1_err_o), 32'h0);
        step(); #1;
        check("wd_err_one_cycle", 32'(m0_err_o), 32'h0);
        check("wd_abort_stb", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
        s_ack_i = 1'b1;
        #1;
        check("wd_late_ack", 32'(m0_ack_o), 32'h0);
        step();
        s_ack_i = 1'b0;
        m0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); #1;
        check("wd_next_gnt", 32'(gnt_o), 32'h2);
        check("wd_next_scyc", 32'(s_cyc_o), 32'h1);
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); step();
`else
        // no watchdog: slave err passes straight through and a hung slave keeps the grant
        m0_set(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        step();
        m1_set(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        for (int c = 0; c < 300; c++) step();
        #1;
        check("hung_gnt", 32'(gnt_o), 32'h1);
        check("hung_stb", 32'(s_stb_o), 32'h1);
        check("hung_no_err", 32'(m0_err_o), 32'h0);
        s_err_i = 1'b1;
        #1;
        check("err_pass_m0", 32'(m0_err_o), 32'h1);
        check("err_pass_m1", 32'(m1_err_o), 32'h0);
        step();
        s_err_i = 1'b0;
        m0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); #1;
        check("err_next_gnt", 32'(gnt_o), 32'h2);
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); step();
`endif

        // asynchronous reset in the middle of a GNT1 transfer
        m1_set(1'b1, 1'b1, 32'h0000_0500, 32'h0000_0077, 4'hF);
        step(); #1;
        check("ar_pre_gnt", 32'(gnt_o), 32'h2);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_gnt", 32'(gnt_o), 32'h0);
        check("ar_scyc", 32'(s_cyc_o), 32'h0);
        check("ar_sadr", s_adr_o, 32'h0);
        m0_set(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
        step();
        reset_n = 1'b1;
        step(); #1;
        check("ar_tie_gnt", 32'(gnt_o), 32'h1);
        check("ar_tie_sadr", s_adr_o, 32'h0000_0600);

        m0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m1_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master, one-slave Wishbone B4 classic arbiter placed between the bus requesters and the `wb_intercon` master port. Lets the core's `wishbone_controller` share the single SoC bus with a second requester (boot loader / DMA) under round-robin grant. Grants are locked for the whole `cyc` of the owning master. An optional watchdog terminates hung transfers.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles of `stb` without `ack`/`err` before watchdog fires; legal range 2..65535.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_adr_i`/`m1_adr_i` in 32: master address.
- `m0_dat_i`/`m1_dat_i` in 32: master write data.
- `m0_sel_i`/`m1_sel_i` in 4: byte selects.
- `m0_we_i`/`m1_we_i` in 1: write enable.
- `m0_cyc_i`/`m1_cyc_i` in 1: bus request / cycle.
- `m0_stb_i`/`m1_stb_i` in 1: strobe.
- `m0_dat_o`/`m1_dat_o` out 32: read data.
- `m0_ack_o`/`m1_ack_o` out 1: ack.
- `m0_err_o`/`m1_err_o` out 1: error.
- `s_adr_o` out 32, `s_dat_o` out 32, `s_sel_o` out 4, `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1: to interconnect.
- `s_dat_i` in 32, `s_ack_i` in 1, `s_err_i` in 1: from interconnect.
- `gnt_o` out 2: one-hot current grant (bit0 = m0); debug/observability.

## Operation
- FSM states: IDLE, GNT0, GNT1. Registered state plus 1-bit `last` (last granted master).
- IDLE: neither `m*_cyc_i` → stay. One requester → grant it. Both → grant the master ≠ `last`.
- GNTx: slave outputs = master x inputs, combinational pass-through. `s_ack_i`/`s_err_i`/`s_dat_i` → master x only. Non-granted master sees `ack=0`, `err=0`, `dat_o=0`.
- GNTx exit on the edge where `mx_cyc_i=0`: other master requesting → GNT(other); else IDLE. `last` ← x on every exit.
- No preemption. Grant changes only on `cyc` deassertion or watchdog.
- In IDLE, all `s_*` outputs are 0.
- Watchdog (see Configuration), 16-bit counter:
  - Clears when not granted or `s_ack_i|s_err_i`.
  - Increments each cycle granted `stb` is high.
  - At count = `TIMEOUT_CYCLES`: one-cycle `mx_err_o` pulse to owner, then `s_cyc_o`/`s_stb_o` forced 0 (ABORT flag) until owner drops `cyc`. Exit follows the normal GNTx rule.
- Reset mid-transfer: state → IDLE, `last` ← 1, counter/ABORT clear; slave outputs drop asynchronously.

## Timing
- Reset values: all outputs 0, `gnt_o=2'b00`, `last=1` (m0 wins the first tie).
- Grant latency: `cyc` rising in cycle N (state IDLE) → `gnt_o` and `s_cyc_o` in N+1.
- Handover: owner `cyc` low in cycle M with other requesting → other master's `s_cyc_o` in M+1. No dead cycle beyond M.
- Data/ack path: zero added latency in both directions while granted.
- Simultaneous owner `cyc` drop and slave `ack` in the same cycle: ack forwarded, grant released at next edge.
- Watchdog err asserted in the cycle the counter reaches `TIMEOUT_CYCLES`. Late `s_ack_i` during ABORT is dropped.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: watchdog counter, ABORT flag and err pulse are compiled in.
- `WB_ARB_TIMEOUT_EN` undefined: no counter; `mx_err_o` is pure pass-through of `s_err_i`; a hung slave holds the grant indefinitely. `TIMEOUT_CYCLES` is ignored.

## Test plan
- Reset → all outputs 0. Only m1 asserts `cyc` at cycle 3 → `gnt_o=2'b10`, `s_adr_o=m1_adr_i` at cycle 4.
- Both request in IDLE after reset → m0 granted. m0 reads 0x1000, slave returns 0xDEADBEEF with ack → `m0_dat_o=0xDEADBEEF`, `m1_ack_o=0`. m0 drops `cyc` → m1 granted next cycle.
- Both continuously issue single-beat cycles for 20 transactions → grants alternate m0,m1,m0…; neither waits more than one transaction.
- m0 holds `cyc` across 4 back-to-back writes (sel=4'b0011) while m1 requests → no grant change until m0 `cyc`=0; all 4 writes seen on slave with correct `sel`.
- (`WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8) m0 strobes, slave never acks → `m0_err_o` pulses at the 8th stb cycle, then `s_stb_o=0`. m0 drops `cyc` → pending m1 granted.
- `reset_n` asserted mid-transfer while GNT1 → `s_cyc_o`, `gnt_o` zero immediately (asynchronous). After release, a tie grants m0.
